osu_sc_chain_checker: RTL and testbench

- Self-test driver and receiver for an external chain of library cells, such as inverter or buffer strings, on test silicon.
- Transmits a PRBS7 stimulus bit on DOUT into the cell chain.
- Receives the chain output on DIN after a fixed register latency.
- Compares DIN against the expected value (delayed stimulus, optionally inverted) and reports error count and pass/fail to the test controller through a start/done handshake.

---
 rtl/osu_sc_chain_checker.sv | 174 +++++++++++++++++
 tb/tb_osu_sc_chain_checker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/osu_sc_chain_checker.sv
// PRBS7 driver/receiver for an external cell chain; DONE pulses LATENCY+LEN+1 edges after the START edge.
// No backpressure: START is ignored while busy. Define OSU_SC_CHAIN_FIRST_FAIL_EN for FAIL_IDX/FAIL_VLD.
module osu_sc_chain_checker #(
    parameter logic INVERT  = 1'b1,
    parameter int   LATENCY = 2,
    parameter int   LEN_W   = 16,
    parameter int   ERR_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    input  logic             DIN,
    output logic             DOUT,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
`ifdef OSU_SC_CHAIN_FIRST_FAIL_EN
    output logic [LEN_W-1:0] FAIL_IDX,
    output logic             FAIL_VLD,
`endif
    output logic [ERR_W-1:0] ERR_CNT
);

    localparam int CNT_W = (LEN_W > 4) ? LEN_W : 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [6:0]         lfsr_q, lfsr_d;
    logic [LATENCY-1:0] dly_q, dly_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               pass_q, pass_d;

    logic               running;
    logic               dout;
    logic               expected;
    logic               mismatch;
    logic               accept;
    logic [LATENCY:0]   dly_chain;

    assign running   = (state_q == S_PRIME) || (state_q == S_RUN);
    assign dout      = running & lfsr_q[6];
    assign expected  = dly_q[LATENCY-1] ^ INVERT;
    // DIN is only looked at in RUN so garbage elsewhere cannot leak into the result.
    assign mismatch  = (state_q == S_RUN) && (DIN != expected);
    assign accept    = (state_q == S_IDLE) && START;
    assign dly_chain = {dly_q, dout};
    assign dly_d     = dly_chain[LATENCY-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        lfsr_d  = lfsr_q;
        err_d   = err_q;
        pass_d  = pass_q;

        if (running) begin
            lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_PRIME;
                    len_d   = LEN;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    lfsr_d  = 7'h7F;
                    cnt_d   = CNT_W'(LATENCY);
                end
            end
            S_PRIME: begin
                if (cnt_q == CNT_W'(1)) begin
                    if (len_q == '0) begin
                        state_d = S_DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = CNT_W'(len_q);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RUN: begin
                if (mismatch && (err_q != '1)) begin
                    err_d = err_q + ERR_W'(1);
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            lfsr_q  <= 7'h7F;
            dly_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            lfsr_q  <= lfsr_d;
            dly_q   <= dly_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

`ifdef OSU_SC_CHAIN_FIRST_FAIL_EN
    logic [LEN_W-1:0] fidx_q, fidx_d;
    logic             fvld_q, fvld_d;
    logic [LEN_W-1:0] run_idx;

    // cnt_q counts down from LEN in RUN, so the bit index is the distance travelled.
    assign run_idx = len_q - cnt_q[LEN_W-1:0];

    always_comb begin
        fidx_d = fidx_q;
        fvld_d = fvld_q;
        if (accept) begin
            fidx_d = '0;
            fvld_d = 1'b0;
        end else if (mismatch && !fvld_q) begin
            fidx_d = run_idx;
            fvld_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fidx_q <= '0;
            fvld_q <= 1'b0;
        end else begin
            fidx_q <= fidx_d;
            fvld_q <= fvld_d;
        end
    end

    assign FAIL_IDX = fidx_q;
    assign FAIL_VLD = fvld_q;
`endif

    assign DOUT    = dout;
    assign BUSY    = (state_q != S_IDLE);
    assign DONE    = (state_q == S_DONE);
    assign PASS    = pass_q;
    assign ERR_CNT = err_q;

endmodule

// File: tb/tb_osu_sc_chain_checker.sv
// Directed bench: three checker instances (inverting, non-inverting, narrow ERR_CNT) on shared controls.
module tb_osu_sc_chain_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [15:0] len;
    logic        stuck;
    logic        flip;
    logic        f1, f2, g1, g2;

    logic        din_a, dout_a, busy_a, done_a, pass_a;
    logic        din_b, dout_b, busy_b, done_b, pass_b;
    logic        din_c, dout_c, busy_c, done_c, pass_c;
    logic [7:0]  err_a, err_b;
    logic [3:0]  err_c;
`ifdef OSU_SC_CHAIN_FIRST_FAIL_EN
    logic [15:0] fidx_a, fidx_b, fidx_c;
    logic        fvld_a, fvld_b, fvld_c;
`endif

    // External chain models: inverting loopback for A, non-inverting (wrong parity) for C.
    always_ff @(posedge clk) begin
        f1 <= ~dout_a;
        f2 <= f1;
        g1 <= dout_c;
        g2 <= g1;
    end
    assign din_a = stuck ? 1'b0 : (f2 ^ flip);
    assign din_b = 1'b0;
    assign din_c = g2;

    osu_sc_chain_checker #(.INVERT(1'b1), .LATENCY(2), .LEN_W(16), .ERR_W(8)) u_a (
        .CLK(clk), .RST(rst), .START(start), .LEN(len), .DIN(din_a), .DOUT(dout_a),
        .BUSY(busy_a), .DONE(done_a), .PASS(pass_a),
`ifdef OSU_SC_CHAIN_FIRST_FAIL_EN
        .FAIL_IDX(fidx_a), .FAIL_VLD(fvld_a),
`endif
        .ERR_CNT(err_a));

    osu_sc_chain_checker #(.INVERT(1'b0), .LATENCY(2), .LEN_W(16), .ERR_W(8)) u_b (
        .CLK(clk), .RST(rst), .START(start), .LEN(len), .DIN(din_b), .DOUT(dout_b),
        .BUSY(busy_b), .DONE(done_b), .PASS(pass_b),
`ifdef OSU_SC_CHAIN_FIRST_FAIL_EN
        .FAIL_IDX(fidx_b), .FAIL_VLD(fvld_b),
`endif
        .ERR_CNT(err_b));

    osu_sc_chain_checker #(.INVERT(1'b1), .LATENCY(2), .LEN_W(16), .ERR_W(4)) u_c (
        .CLK(clk), .RST(rst), .START(start), .LEN(len), .DIN(din_c), .DOUT(dout_c),
        .BUSY(busy_c), .DONE(done_c), .PASS(pass_c),
`ifdef OSU_SC_CHAIN_FIRST_FAIL_EN
        .FAIL_IDX(fidx_c), .FAIL_VLD(fvld_c),
`endif
        .ERR_CNT(err_c));

    int   sel;
    logic done_s, busy_s, pass_s, dout_s;
    int   err_s;
`ifdef OSU_SC_CHAIN_FIRST_FAIL_EN
    int   fidx_s;
    logic fvld_s;
`endif

    always_comb begin
        done_s = done_a; busy_s = busy_a; pass_s = pass_a; dout_s = dout_a; err_s = int'(err_a);
`ifdef OSU_SC_CHAIN_FIRST_FAIL_EN
        fidx_s = int'(fidx_a); fvld_s = fvld_a;
`endif
        if (sel == 1) begin
            done_s = done_b; busy_s = busy_b; pass_s = pass_b; dout_s = dout_b; err_s = int'(err_b);
`ifdef OSU_SC_CHAIN_FIRST_FAIL_EN
            fidx_s = int'(fidx_b); fvld_s = fvld_b;
`endif
        end else if (sel == 2) begin
            done_s = done_c; busy_s = busy_c; pass_s = pass_c; dout_s = dout_c; err_s = int'(err_c);
`ifdef OSU_SC_CHAIN_FIRST_FAIL_EN
            fidx_s = int'(fidx_c); fvld_s = fvld_c;
`endif
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int len;
        int mode;       // 0 = good loopback on A, 1 = A's DIN stuck at 0
        int inj_t;      // negedge index at which A's DIN is flipped (0 = never)
        int restart_t;  // negedge index at which START is re-pulsed (0 = never)
        int inst;       // 0 = A (INVERT=1), 1 = B (INVERT=0, DIN=0), 2 = C (ERR_W=4, wrong parity)
        int exp_err;
        int exp_pass;
        int exp_edges;
        int exp_fidx;   // -1 = no mismatch expected
    } vec_t;

    // Negedge t lies between posedge t-1 and t; START edge is posedge 0.
    task automatic run_row(input vec_t v, input int row);
        int t;
        sel   = v.inst;
        stuck = (v.mode == 1);
        flip  = 1'b0;
        @(negedge clk);
        len   = 16'(v.len);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        len   = 16'hA5A5;
        t = 0;
        while (t < v.len + 40) begin
            @(negedge clk);
            t++;
            start = (t == v.restart_t);
            flip  = (t == v.inj_t);
            if (done_s) break;
        end
        chk($sformatf("row%0d_edges", row), t, v.exp_edges);
        chk($sformatf("row%0d_done", row), int'(done_s), 1);
        chk($sformatf("row%0d_err", row), err_s, v.exp_err);
        chk($sformatf("row%0d_pass", row), int'(pass_s), v.exp_pass);
`ifdef OSU_SC_CHAIN_FIRST_FAIL_EN
        chk($sformatf("row%0d_fvld", row), int'(fvld_s), (v.exp_fidx >= 0) ? 1 : 0);
        if (v.exp_fidx >= 0) chk($sformatf("row%0d_fidx", row), fidx_s, v.exp_fidx);
`endif
        @(negedge clk);
        start = 1'b0;
        flip  = 1'b0;
        chk($sformatf("row%0d_done_1cyc", row), int'(done_s), 0);
        chk($sformatf("row%0d_idle", row), int'(busy_s), 0);
        chk($sformatf("row%0d_dout_idle", row), int'(dout_s), 0);
        chk($sformatf("row%0d_pass_hold", row), int'(pass_s), v.exp_pass);
        chk($sformatf("row%0d_err_hold", row), err_s, v.exp_err);
    endtask

    vec_t vecs[12];
    int   ndone;

    initial begin
        // len mode inj restart inst err pass edges fidx
        vecs[0]  = '{300, 0, 0,  0, 0,   0, 1, 303, -1};
        vecs[1]  = '{127, 1, 0,  0, 1,  64, 0, 130,  0};
        vecs[2]  = '{127, 1, 0,  0, 0,  63, 0, 130,  7};
        vecs[3]  = '{ 20, 0, 0,  0, 2,  15, 0,  23,  0};
        vecs[4]  = '{  0, 0, 0,  0, 0,   0, 1,   3, -1};
        vecs[5]  = '{ 50, 0, 0, 20, 0,   0, 1,  53, -1};
        vecs[6]  = '{254, 1, 0,  0, 1, 128, 0, 257,  0};
        vecs[7]  = '{  8, 1, 0,  0, 0,   1, 0,  11,  7};
        vecs[8]  = '{  7, 1, 0,  0, 1,   7, 0,  10,  0};
        vecs[9]  = '{100, 0, 40, 0, 0,   1, 0, 103, 37};
        vecs[10] = '{  4, 0, 0,  7, 0,   0, 1,   7, -1};
        vecs[11] = '{  1, 0, 0,  0, 0,   0, 1,   4, -1};

        rst = 1'b1; start = 1'b0; len = 16'd0; stuck = 1'b0; flip = 1'b0; sel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dout", int'(dout_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_pass", int'(pass_a), 0);
        chk("rst_err", int'(err_a), 0);
`ifdef OSU_SC_CHAIN_FIRST_FAIL_EN
        chk("rst_fvld", int'(fvld_a), 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_row(vecs[i], i);

        // Reset in the middle of RUN on B: errors so far are bits 0..6 (all ones).
        sel = 1; stuck = 1'b1;
        @(negedge clk);
        len = 16'd50; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 10; i++) @(negedge clk);
        chk("midrst_pre_err", int'(err_b), 7);
        chk("midrst_pre_busy", int'(busy_b), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", int'(busy_b), 0);
        chk("midrst_dout", int'(dout_b), 0);
        chk("midrst_err", int'(err_b), 0);
        chk("midrst_done", int'(done_b), 0);
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_b) ndone++;
        end
        chk("midrst_no_done", ndone, 0);

        run_row('{10, 0, 0, 0, 0, 0, 1, 13, -1}, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
